// File: rtl/icache_direct_mapped.sv
// Direct-mapped, read-only instruction cache: 32-bit words from 128-bit lines,
// zero-latency hits, single-line refill from slow memory on a miss.
module icache_direct_mapped #(
   parameter int NUM_BLOCKS = 8,
   parameter int INDEX_W    = 3,
   parameter int TAG_W      = 28 - INDEX_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         proc_read,
   input  logic         proc_write,
   input  logic [29:0]  proc_addr,
   input  logic [31:0]  proc_wdata,
   output logic         proc_stall,
   output logic [31:0]  proc_rdata,
   output logic         mem_read,
   output logic         mem_write,
   output logic [27:0]  mem_addr,
   output logic [127:0] mem_wdata,
   input  logic [127:0] mem_rdata,
   input  logic         mem_ready
);

   typedef enum logic {IDLE, FETCH} state_t;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [3:0][31:0] data;
   } line_t;

   state_t                state, state_nxt;
   logic [NUM_BLOCKS-1:0] valid;
   line_t                 lines [NUM_BLOCKS];
   logic [27:0]           miss_addr;

   logic [INDEX_W-1:0]    p_idx, m_idx;
   logic [TAG_W-1:0]      p_tag, m_tag;
   line_t                 p_line;
   logic                  hit, miss_req, fill;

   assign p_idx    = proc_addr[INDEX_W+1:2];
   assign p_tag    = proc_addr[29:INDEX_W+2];
   assign m_idx    = miss_addr[INDEX_W-1:0];
   assign m_tag    = miss_addr[27:INDEX_W];
   assign p_line   = lines[p_idx];
   assign hit      = valid[p_idx] && (p_line.tag == p_tag);
   assign miss_req = (state == IDLE) && proc_read && !hit;
   assign fill     = (state == FETCH) && mem_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid     <= '0;
         miss_addr <= '0;
      end else begin
         if (miss_req) miss_addr    <= proc_addr[29:2];
         if (fill)     valid[m_idx] <= 1'b1;
      end
   end

   // Tag/data arrays carry no reset; the valid bits alone qualify them.
   always_ff @(posedge clk) begin
      if (fill && rst_n) begin
         lines[m_idx].tag  <= m_tag;
         lines[m_idx].data <= mem_rdata;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (miss_req)  state_nxt = FETCH;
         FETCH:   if (mem_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // mem_addr comes only from the latched miss address, so a core that moves
   // proc_addr mid-fetch cannot redirect the refill.
   always_comb begin
      mem_read   = 1'b0;
      mem_addr   = '0;
      proc_stall = 1'b0;
      case (state)
         IDLE:    proc_stall = miss_req;
         FETCH: begin
            mem_read   = 1'b1;
            mem_addr   = miss_addr;
            proc_stall = 1'b1;
         end
         default: ;
      endcase
   end

   assign proc_rdata = p_line.data[proc_addr[1:0]];
   assign mem_write  = 1'b0;
   assign mem_wdata  = '0;

   logic unused_in;
   assign unused_in = ^{proc_write, proc_wdata};

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Directed + randomized bench for icache_direct_mapped against a line-address
// reference model of the cache contents.
module tb_icache_direct_mapped;

   localparam int NB = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         proc_read = 1'b0;
   logic         proc_write = 1'b0;
   logic [29:0]  proc_addr = '0;
   logic [31:0]  proc_wdata = '0;
   logic         proc_stall;
   logic [31:0]  proc_rdata;
   logic         mem_read;
   logic         mem_write;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata = '0;
   logic         mem_ready = 1'b0;

   always #5 clk = ~clk;

   icache_direct_mapped #(.NUM_BLOCKS(NB), .INDEX_W(3), .TAG_W(25)) dut (
      .clk(clk), .rst_n(rst_n),
      .proc_read(proc_read), .proc_write(proc_write), .proc_addr(proc_addr),
      .proc_wdata(proc_wdata), .proc_stall(proc_stall), .proc_rdata(proc_rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   int n_chk = 0;
   int n_pass = 0;

   // Model: which line address each slot holds, and its contents.
   logic         m_valid [NB];
   logic [27:0]  m_la    [NB];
   logic [127:0] m_data  [NB];

   function automatic logic [127:0] line_data(input logic [27:0] la);
      if (la == 28'd1) return 128'h33333333_22222222_11111111_00000000;
      return {4'h3, la, 4'h2, la, 4'h1, la, 4'h0, la};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_clear();
      for (int i = 0; i < NB; i++) m_valid[i] = 1'b0;
   endtask

   // One fetch; memory answers in the lat-th FETCH cycle.
   task automatic rd(input logic [29:0] a, input int lat);
      logic [27:0] la;
      int          idx, stalls, fcyc, w;
      bit          exp_hit;
      la      = a[29:2];
      idx     = int'(la[2:0]);
      w       = int'(a[1:0]);
      stalls  = 0;
      fcyc    = 0;
      exp_hit = m_valid[idx] && (m_la[idx] == la);
      @(negedge clk);
      proc_read = 1'b1;
      proc_addr = a;
      #1;
      for (int c = 0; c < lat + 20 && proc_stall; c++) begin
         if (c == 0) chk("mem_read_request_cycle", mem_read, 1'b0);
         stalls++;
         if (mem_read) begin
            fcyc++;
            chk("mem_addr", mem_addr, la);
            if (fcyc == lat) begin
               mem_ready = 1'b1;
               mem_rdata = line_data(la);
            end
         end
         @(negedge clk);
         mem_ready = 1'b0;
         #1;
      end
      if (!exp_hit) begin
         m_valid[idx] = 1'b1;
         m_la[idx]    = la;
         m_data[idx]  = line_data(la);
      end
      chk("stall_cycles", stalls, exp_hit ? 0 : lat + 1);
      chk("proc_stall_after", proc_stall, 1'b0);
      chk("proc_rdata", proc_rdata, m_data[idx][w*32 +: 32]);
      chk("mem_read_after", mem_read, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [29:0] a;
      model_clear();

      // Reset state
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_proc_stall", proc_stall, 1'b0);
      chk("rst_mem_read",   mem_read,   1'b0);
      chk("rst_mem_write",  mem_write,  1'b0);
      chk("rst_mem_wdata",  mem_wdata,  128'h0);
      chk("rst_mem_addr",   mem_addr,   28'h0);

      // Cold miss, same-line hit, conflict and re-miss
      rd(30'h5, 10);
      rd(30'h7, 2);
      rd(30'h25, 4);
      rd(30'h5, 3);

      // Fill every index, then re-read all eight
      for (int i = 0; i < NB; i++) rd(30'(i * 4), 1 + i % 3);
      for (int i = 0; i < NB; i++) rd(30'(i * 4 + i % 4), 2);

      // Idle with write request and spurious mem_ready
      @(negedge clk);
      proc_read  = 1'b0;
      proc_write = 1'b1;
      for (int i = 0; i < 3; i++) begin
         proc_wdata = $urandom;
         proc_addr  = 30'($urandom_range(0, 255));
         mem_rdata  = {$urandom, $urandom, $urandom, $urandom};
         mem_ready  = 1'b1;
         #1;
         chk("idle_proc_stall", proc_stall, 1'b0);
         chk("idle_mem_read",   mem_read,   1'b0);
         chk("idle_mem_write",  mem_write,  1'b0);
         @(negedge clk);
      end
      mem_ready  = 1'b0;
      proc_write = 1'b0;
      for (int i = 0; i < NB; i++) rd(30'(i * 4 + 3), 2);

      // Randomized traffic over a small tag space to force conflicts
      repeat (60) begin
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            proc_read = 1'b0;
         end
         a = 30'($urandom_range(0, 255));
         rd(a, $urandom_range(1, 6));
      end

      // Reset in the middle of a fetch
      @(negedge clk);
      proc_read = 1'b1;
      proc_addr = 30'h3C5;
      repeat (3) @(negedge clk);
      #1;
      chk("midfetch_mem_read", mem_read, 1'b1);
      @(negedge clk);
      rst_n     = 1'b0;
      proc_read = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("midfetch_reset_mem_read", mem_read, 1'b0);
      @(negedge clk);
      mem_ready = 1'b1;
      mem_rdata = line_data(28'hF1);
      #1;
      chk("midfetch_spurious_mem_read", mem_read, 1'b0);
      @(negedge clk);
      mem_ready = 1'b0;
      model_clear();
      rd(30'h10, 2);
      rd(30'h3C5, 3);
      rd(30'h10, 1);

      @(negedge clk);
      proc_read = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/icache_direct_mapped.md
Name: icache_direct_mapped

Overview:
- Read-only, direct-mapped instruction cache between the RISC-V core's fetch stage and the instruction-side slow memory (mem_*_I bus inside CHIP).
- Serves 32-bit instruction words from 128-bit (4-word) lines.
- On a miss it stalls the core, fetches one line from slow memory over the mem_read/mem_ready handshake, and refills the line.

Parameters:
- NUM_BLOCKS, 8, number of cache lines (power of 2).
- INDEX_W, 3, log2(NUM_BLOCKS).
- TAG_W, 25, equal to 28 - INDEX_W; word-address tag bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- proc_read  input  1  core requests an instruction word.
- proc_write  input  1  ignored (I-side is read-only); no effect on state.
- proc_addr  input  30  word address: [1:0] word offset, [INDEX_W+1:2] index, [29:INDEX_W+2] tag.
- proc_wdata  input  32  ignored.
- proc_stall  output  1  high while the requested word is not available.
- proc_rdata  output  32  requested instruction word; valid when proc_read=1 and proc_stall=0.
- mem_read  output  1  line read request to slow memory.
- mem_write  output  1  tied 0.
- mem_addr  output  28  line address (byte address bits [31:4]).
- mem_wdata  output  128  tied 0.
- mem_rdata  input  128  line data; word 0 in bits [31:0], word 3 in [127:96].
- mem_ready  input  1  one-cycle pulse; mem_rdata valid in the same cycle.

Behaviour:
- Storage: per line, a valid bit, a TAG_W tag and a 128-bit data word.
- Hit: proc_read=1, valid[index]=1 and tag[index]=proc_addr tag. Hit evaluation is combinational.
- Hit response: proc_stall=0 and proc_rdata=line word selected by proc_addr[1:0] in the same cycle (zero-latency hit).
- No request: when proc_read=0, proc_stall=0; proc_rdata is don't-care (drive the selected word anyway).
- FSM states: IDLE, FETCH.
- IDLE:
  - mem_read=0.
  - If proc_read=1 and miss: proc_stall=1 combinationally, latch proc_addr[29:2] into miss_addr, go to FETCH.
  - Otherwise stay in IDLE.
- FETCH:
  - mem_read=1, mem_addr=miss_addr, proc_stall=1.
  - mem_addr is driven only from the latched miss_addr, never from live proc_addr.
  - Hold until mem_ready=1.
  - On the mem_ready cycle: write mem_rdata into data[miss index], set tag[miss index], set valid=1, go to IDLE. proc_stall remains 1 in that cycle.
- Miss latency: proc_stall rises in the request cycle and falls in the first IDLE cycle after mem_ready (a hit). Total stall cycles = memory latency + 1.
- Core address stability: the core holds proc_addr/proc_read stable while stalled. If proc_addr changes during FETCH anyway:
  - the fill still targets miss_addr;
  - the new address is re-evaluated in IDLE (it may miss again).
- mem_ready while in IDLE: ignored, no state change.
- Conflict miss: a new tag at the same index overwrites the line. No write-back, since lines are never dirty.
- Reset (rst_n=0 at a rising edge), including mid-FETCH:
  - state=IDLE and all valid bits cleared;
  - mem_read=0 from the next cycle;
  - tags/data need no reset;
  - a pending slow-memory response is ignored.
- Reset output values: proc_stall=0 when proc_read=0, mem_read=0, mem_write=0, mem_wdata=0, mem_addr=0.
- All outputs depend only on state registers, latched address and proc_* inputs. There is no combinational path from mem_ready to mem_read.

Test Plan:
- Cold miss: after reset, proc_read=1, proc_addr=30'h00000005, memory returns 128'h33333333_22222222_11111111_00000000 after 10 cycles -> mem_read=1 with mem_addr=28'h0000001 until mem_ready; proc_stall high 11 cycles; then proc_rdata=32'h11111111, proc_stall=0.
- Hit same line: proc_addr=30'h00000007 immediately after the fill -> proc_stall=0 same cycle, proc_rdata=32'h33333333, mem_read stays 0.
- Conflict: proc_addr=30'h00000025 (same index 1, different tag) -> miss, mem_addr=28'h0000009, refill. A subsequent 30'h00000005 misses again.
- Distinct indices: fill lines 0..7 (addresses 0,4,...,28), then re-read all eight -> zero stall cycles on every re-read.
- Reset mid-FETCH: assert rst_n=0 while mem_read=1 -> mem_read=0 next cycle; the mem_ready pulse that follows writes nothing; re-reading the prior hit address misses.
- Idle/ignored inputs: proc_read=0 with proc_write=1 and a spurious mem_ready -> proc_stall=0, mem_read=0, mem_write=0, no valid bit changes.
